// File: rtl/mem_port_if.sv
// Requester-side port of the memory arbiter: one request/response channel per requester.
// A requester raises req with stable we/addr/wdata and holds them until rvalid; gnt marks the accepting cycle.
interface mem_port_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the unified core memory: core (C) has priority, debug port (D)
// is forced through after MAX_WAIT consecutive C grants. One transaction in flight at a time.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  mem_port_if.slave                      c_if,
  mem_port_if.slave                      d_if,
  output logic                           m_en,
  output logic                           m_we,
  output logic [AW-1:0]                  m_addr,
  output logic [DW-1:0]                  m_wdata,
  input  logic [DW-1:0]                  m_rdata,
  output logic                           dbg_state,
  output logic [$clog2(MAX_WAIT+1)-1:0]  dbg_wait_cnt
);
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam int LCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);
  localparam logic [LCW-1:0] LAT_INIT = LCW'(MEM_LAT - 1);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic           owner_q, owner_d;   // 0 = C, 1 = D
  logic [LCW-1:0] lat_q, lat_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           grant;
  logic           pick_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      lat_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lat_q   <= lat_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_d       = lat_q;
    wait_d      = wait_q;
    grant       = 1'b0;
    pick_d      = 1'b0;
    m_en        = 1'b0;
    m_we        = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    c_if.gnt    = 1'b0;
    c_if.rvalid = 1'b0;
    c_if.rdata  = '0;
    d_if.gnt    = 1'b0;
    d_if.rvalid = 1'b0;
    d_if.rdata  = '0;

    case (state_q)
      IDLE: begin
        // Grant is combinational, so it must be masked while reset is held.
        if (!rst && (c_if.req || d_if.req)) begin
          grant   = 1'b1;
          pick_d  = d_if.req && (!c_if.req || (wait_q == WAIT_MAX));
          owner_d = pick_d;
          lat_d   = LAT_INIT;
          state_d = WAIT;
          m_en    = 1'b1;
          if (pick_d) begin
            d_if.gnt = 1'b1;
            m_we     = d_if.we;
            m_addr   = d_if.addr;
            m_wdata  = d_if.wdata;
          end else begin
            c_if.gnt = 1'b1;
            m_we     = c_if.we;
            m_addr   = c_if.addr;
            m_wdata  = c_if.wdata;
          end
        end
      end
      WAIT: begin
        if (lat_q != '0) begin
          lat_d = lat_q - 1'b1;
        end else begin
          state_d = IDLE;
          if (owner_q) begin
            d_if.rvalid = 1'b1;
            d_if.rdata  = m_rdata;
          end else begin
            c_if.rvalid = 1'b1;
            c_if.rdata  = m_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Counts C grants that overtook a pending D request.
    if (!d_if.req || (grant && pick_d)) begin
      wait_d = '0;
    end else if (grant && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  assign dbg_state    = state_q;
  assign dbg_wait_cnt = wait_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic rst;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mem_port_if #(.AW(AW), .DW(DW)) c1 ();
  mem_port_if #(.AW(AW), .DW(DW)) d1 ();
  mem_port_if #(.AW(AW), .DW(DW)) c3 ();
  mem_port_if #(.AW(AW), .DW(DW)) d3 ();

  logic          m1_en, m1_we, m3_en, m3_we;
  logic [AW-1:0] m1_addr, m3_addr;
  logic [DW-1:0] m1_wdata, m3_wdata, m1_rdata, m3_rdata;
  logic          dbg1_state, dbg3_state;
  logic [2:0]    dbg1_wait, dbg3_wait;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .MAX_WAIT(4)) dut1 (
    .clk(clk), .rst(rst), .c_if(c1), .d_if(d1),
    .m_en(m1_en), .m_we(m1_we), .m_addr(m1_addr), .m_wdata(m1_wdata), .m_rdata(m1_rdata),
    .dbg_state(dbg1_state), .dbg_wait_cnt(dbg1_wait)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .MAX_WAIT(4)) dut3 (
    .clk(clk), .rst(rst), .c_if(c3), .d_if(d3),
    .m_en(m3_en), .m_we(m3_we), .m_addr(m3_addr), .m_wdata(m3_wdata), .m_rdata(m3_rdata),
    .dbg_state(dbg3_state), .dbg_wait_cnt(dbg3_wait)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] exp_wait;
  logic       is_d;
  logic       found;

  initial begin
    rst = 1'b1;
    c1.req = 1'b1; c1.we = 1'b0; c1.addr = 32'h10; c1.wdata = '0;
    d1.req = 1'b1; d1.we = 1'b1; d1.addr = 32'h20; d1.wdata = 32'h55;
    c3.req = 1'b0; c3.we = 1'b0; c3.addr = '0;     c3.wdata = '0;
    d3.req = 1'b0; d3.we = 1'b0; d3.addr = '0;     d3.wdata = '0;
    m1_rdata = 32'hDEADBEEF;
    m3_rdata = '0;

    // Reset held with both requests pending: everything quiet.
    sample(); sample();
    check("rst_c_gnt",  c1.gnt,     0);
    check("rst_d_gnt",  d1.gnt,     0);
    check("rst_m_en",   m1_en,      0);
    check("rst_m_addr", m1_addr,    0);
    check("rst_m_wdat", m1_wdata,   0);
    check("rst_c_rval", c1.rvalid,  0);
    check("rst_state",  dbg1_state, 0);

    // Release: C wins in the first IDLE cycle (t), read of 0x10.
    drive_edge(); rst = 1'b0;
    sample();
    check("t_c_gnt",  c1.gnt,  1);
    check("t_d_gnt",  d1.gnt,  0);
    check("t_m_en",   m1_en,   1);
    check("t_m_we",   m1_we,   0);
    check("t_m_addr", m1_addr, 32'h10);
    sample(); // t+1
    check("t1_c_rval",  c1.rvalid, 1);
    check("t1_c_rdata", c1.rdata,  32'hDEADBEEF);
    check("t1_d_gnt",   d1.gnt,    0);
    check("t1_d_rval",  d1.rvalid, 0);
    check("t1_d_rdata", d1.rdata,  0);
    check("t1_m_en",    m1_en,     0);

    // D was pending through the C rvalid; its write is granted at t+2.
    drive_edge(); c1.req = 1'b0;
    sample();
    check("t2_state",   dbg1_state, 0);
    check("dw_d_gnt",   d1.gnt,     1);
    check("dw_c_gnt",   c1.gnt,     0);
    check("dw_m_we",    m1_we,      1);
    check("dw_m_addr",  m1_addr,    32'h20);
    check("dw_m_wdata", m1_wdata,   32'h55);
    check("dw_wait",    dbg1_wait,  1);
    check("dw_c_rval",  c1.rvalid,  0);
    sample();
    check("dw_d_rval",   d1.rvalid, 1);
    check("dw_c_rval2",  c1.rvalid, 0);
    check("dw_m_en",     m1_en,     0);
    check("dw_wait_clr", dbg1_wait, 0);
    drive_edge(); d1.req = 1'b0;
    sample();
    check("idle_m_en", m1_en, 0);

    // Starvation: both requests held, order C,C,C,C,D repeating.
    drive_edge();
    c1.req = 1'b1; c1.we = 1'b0; c1.addr = 32'h40;
    d1.req = 1'b1; d1.we = 1'b0; d1.addr = 32'h80;
    m1_rdata = 32'h1234;
    exp_wait = 3'd0;
    for (int g = 0; g < 10; g++) begin
      found = 1'b0;
      for (int k = 0; k < 6 && !found; k++) begin
        sample();
        if (c1.gnt || d1.gnt) found = 1'b1;
      end
      check("sv_gnt_seen", found, 1);
      is_d = (g % 5 == 4);
      check("sv_order", {c1.gnt, d1.gnt}, is_d ? 2'b01 : 2'b10);
      check("sv_wait",  dbg1_wait, exp_wait);
      check("sv_addr",  m1_addr, is_d ? 32'h80 : 32'h40);
      exp_wait = is_d ? 3'd0 : ((exp_wait == 3'd4) ? 3'd4 : exp_wait + 3'd1);
      sample();
      check("sv_rval", {c1.rvalid, d1.rvalid}, is_d ? 2'b01 : 2'b10);
    end
    drive_edge(); c1.req = 1'b0; d1.req = 1'b0;
    sample();
    check("sv_idle", {c1.gnt, d1.gnt, m1_en}, 3'b000);

    // Reset pulsed during WAIT: in-flight C read is dropped.
    drive_edge(); c1.req = 1'b1; c1.addr = 32'h60;
    sample();
    check("rw_c_gnt", c1.gnt, 1);
    drive_edge();
    rst = 1'b1;
    c1.req = 1'b0;
    d1.req = 1'b1; d1.we = 1'b0; d1.addr = 32'h70;
    sample();
    check("rw_c_rval", c1.rvalid,  0);
    check("rw_state",  dbg1_state, 0);
    check("rw_d_gnt",  d1.gnt,     0);
    check("rw_m_en",   m1_en,      0);
    drive_edge(); rst = 1'b0;
    sample();
    check("rw_d_gnt1",  d1.gnt,  1);
    check("rw_c_gnt1",  c1.gnt,  0);
    check("rw_m_addr",  m1_addr, 32'h70);
    sample();
    check("rw_d_rval",  d1.rvalid, 1);
    drive_edge(); d1.req = 1'b0;

    // MEM_LAT=3: rvalid exactly 3 cycles after m_en; address change in WAIT ignored.
    c3.req = 1'b1; c3.we = 1'b0; c3.addr = 32'h30;
    m3_rdata = 32'hCAFEF00D;
    sample();
    check("l3_gnt",    c3.gnt,  1);
    check("l3_m_en",   m3_en,   1);
    check("l3_m_addr", m3_addr, 32'h30);
    drive_edge(); c3.addr = 32'h99;
    for (int i = 0; i < 2; i++) begin
      sample();
      check("l3_w_m_en", m3_en,     0);
      check("l3_w_gnt",  c3.gnt,    0);
      check("l3_w_rval", c3.rvalid, 0);
    end
    sample();
    check("l3_rval",  c3.rvalid, 1);
    check("l3_rdata", c3.rdata,  32'hCAFEF00D);
    check("l3_m_en3", m3_en,     0);
    check("l3_d_rv",  d3.rvalid, 0);
    drive_edge(); c3.req = 1'b0;
    sample();
    check("l3_after", {m3_en, c3.rvalid}, 2'b00);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
